// File: rtl/priority_arbiter_8.sv
// priority_arbiter_8: 8-client arbiter for one shared resource.
// Index 7 has the highest priority, and the outputs are registered.
// An owner keeps the grant until it releases, drops its request or the
// hold watchdog fires. A one-cycle GAP always separates two owners.
// The owner's release line is named release_grant because `release` is a
// reserved word in SystemVerilog.
// Optional build macro ROUND_ROBIN_EN: the IDLE search rotates. It starts
// just below the last owner and wraps downward. When the macro is undefined,
// the highest set index always wins.
module priority_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16  // 0 disables the watchdog; 0..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       release_grant,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam bit         HOLD_EN  = (MAX_HOLD != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] hold_cnt, hold_cnt_nxt;
  logic [2:0] last_idx, last_idx_nxt;
  logic [7:0] gnt_nxt;
  logic [2:0] gnt_idx_nxt;
  logic       gnt_valid_nxt;
  logic       timeout_nxt;

  logic [2:0] search_start;
  logic [2:0] cand;
  logic [2:0] win_idx;
  logic       win_found;

`ifdef ROUND_ROBIN_EN
  assign search_start = last_idx - 3'd1;
`else
  // last_idx is still tracked, but fixed priority never reads it.
  logic unused_last_idx;
  assign unused_last_idx = ^last_idx;
  assign search_start    = 3'd7;
`endif

  // Winner search: walk downward from search_start with wrap-around and keep the first requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = search_start;
    for (int k = 0; k < 8; k++) begin
      cand = search_start - 3'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic for IDLE -> GRANT -> GAP -> IDLE.
  always_comb begin
    state_nxt     = state;
    hold_cnt_nxt  = hold_cnt;
    last_idx_nxt  = last_idx;
    gnt_nxt       = gnt;
    gnt_idx_nxt   = gnt_idx;
    gnt_valid_nxt = gnt_valid;
    timeout_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt     = GRANT;
          gnt_nxt       = 8'd1 << win_idx;
          gnt_idx_nxt   = win_idx;
          gnt_valid_nxt = 1'b1;
          hold_cnt_nxt  = 8'd1;
          last_idx_nxt  = win_idx;
        end
      end
      GRANT: begin
        // A normal release takes precedence over the watchdog when both occur in the same cycle.
        if (release_grant || !req[gnt_idx]) begin
          state_nxt     = GAP;
          gnt_nxt       = 8'd0;
          gnt_idx_nxt   = 3'd0;
          gnt_valid_nxt = 1'b0;
          hold_cnt_nxt  = 8'd0;
        end else if (HOLD_EN && (hold_cnt == HOLD_LIM)) begin
          state_nxt     = GAP;
          gnt_nxt       = 8'd0;
          gnt_idx_nxt   = 3'd0;
          gnt_valid_nxt = 1'b0;
          hold_cnt_nxt  = 8'd0;
          timeout_nxt   = 1'b1;
        end else begin
          hold_cnt_nxt  = hold_cnt + 8'd1;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt     = IDLE;
        gnt_nxt       = 8'd0;
        gnt_idx_nxt   = 3'd0;
        gnt_valid_nxt = 1'b0;
        hold_cnt_nxt  = 8'd0;
      end
    endcase
  end

  // State and output registers; reset wins over every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= 8'd0;
      last_idx  <= 3'd0;
      gnt       <= 8'd0;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_cnt_nxt;
      last_idx  <= last_idx_nxt;
      gnt       <= gnt_nxt;
      gnt_idx   <= gnt_idx_nxt;
      gnt_valid <= gnt_valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_priority_arbiter_8.sv
// tb_priority_arbiter_8: this bench drives directed and random requests.
// It compares every cycle against an owner/gap reference model.
module tb_priority_arbiter_8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       release_grant;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner index (-1 = nobody), cycles held, gap flag, watchdog flag, last owner.
  int m_owner = -1;
  int m_hold  = 0;
  bit m_gap   = 1'b0;
  bit m_to    = 1'b0;
  int m_last  = 0;

  priority_arbiter_8 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .release_grant(release_grant),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int last);
`ifdef ROUND_ROBIN_EN
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (((last - 1 - k) % 8) + 8) % 8;
      if (r[i]) return i;
    end
`else
    for (int i = 7; i >= 0; i--) if (r[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [7:0] q, input logic rl);
    int w;
    if (r) begin
      m_owner = -1; m_hold = 0; m_gap = 0; m_to = 0; m_last = 0;
    end else if (m_owner >= 0) begin
      if (rl || !q[m_owner]) begin
        m_owner = -1; m_gap = 1; m_to = 0;
      end else if (MH != 0 && m_hold == MH) begin
        m_owner = -1; m_gap = 1; m_to = 1;
      end else begin
        m_hold++;
      end
    end else if (m_gap) begin
      m_gap = 0; m_to = 0;
    end else begin
      w = pick(q, m_last);
      m_to = 0;
      if (w >= 0) begin
        m_owner = w; m_hold = 1; m_last = w;
      end
    end
  endtask

  task automatic check_model();
    logic [7:0] e_gnt;
    e_gnt = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("gnt_idx", 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    chk("timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic cyc(input logic r, input logic [7:0] q, input logic rl);
    @(negedge clk);
    rst = r; req = q; release_grant = rl;
    @(posedge clk);
    model_step(r, q, rl);
    #1;
    check_model();
  endtask

  initial begin
    logic [7:0] rq;
    rst = 1'b1; req = 8'd0; release_grant = 1'b0;
    cyc(1, 8'h00, 0);
    cyc(1, 8'hFF, 1);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_valid", 32'(gnt_valid), 32'd0);

    // Fixed-priority pick, release, gap, then regrant
    cyc(0, 8'b0010_0100, 0);
    chk("tp_idx5", 32'(gnt_idx), 32'd5);
    chk("tp_gnt5", 32'(gnt), 32'h20);
    cyc(0, 8'b0010_0100, 0);
    cyc(0, 8'b0010_0100, 0);
    cyc(0, 8'b0010_0100, 1);
    chk("tp_gap", 32'(gnt), 32'd0);
    cyc(0, 8'b0000_0100, 0);
    chk("tp_idle", 32'(gnt), 32'd0);
    cyc(0, 8'b0000_0100, 0);
    chk("tp_idx2", 32'(gnt_idx), 32'd2);
    cyc(0, 8'b0000_0000, 0);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);

    // Request drop ends the grant without timeout
    cyc(0, 8'h08, 0);
    chk("drop_own3", 32'(gnt_idx), 32'd3);
    cyc(0, 8'h00, 0);
    chk("drop_clear", 32'(gnt_valid), 32'd0);
    chk("drop_noto", 32'(timeout), 32'd0);
    cyc(0, 8'h00, 0);

    // Watchdog: MH cycles of grant, then GAP with timeout, IDLE, then regrant
    cyc(0, 8'h01, 0);
    for (int i = 0; i < MH - 1; i++) cyc(0, 8'h01, 0);
    chk("wd_still", 32'(gnt), 32'h01);
    cyc(0, 8'h01, 0);
    chk("wd_pulse", 32'(timeout), 32'd1);
    chk("wd_gap", 32'(gnt), 32'd0);
    cyc(0, 8'h01, 0);
    chk("wd_pulse_end", 32'(timeout), 32'd0);
    cyc(0, 8'h01, 0);
    chk("wd_regrant", 32'(gnt), 32'h01);
    for (int i = 0; i < MH - 1; i++) cyc(0, 8'h01, 0);
    cyc(0, 8'h01, 1);
    chk("wd_rel_wins", 32'(timeout), 32'd0);
    cyc(0, 8'h00, 0);

    // Reset during a grant
    cyc(0, 8'h40, 0);
    chk("rst_own6", 32'(gnt_idx), 32'd6);
    cyc(1, 8'h40, 0);
    chk("rst_mid_gnt", 32'(gnt), 32'd0);
    cyc(0, 8'h40, 0);
    chk("rst_regrant6", 32'(gnt_idx), 32'd6);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);

    // No pre-emption by a higher index
    cyc(0, 8'h02, 0);
    cyc(0, 8'h82, 0);
    chk("nopre_hold", 32'(gnt), 32'h02);
    cyc(0, 8'h82, 1);
    cyc(0, 8'h80, 0);
    cyc(0, 8'h80, 0);
    chk("nopre_next7", 32'(gnt_idx), 32'd7);
    cyc(0, 8'h00, 0);

    // All requesters with a release pulse on each first grant cycle
    cyc(1, 8'h00, 0);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 8'hFF, 0);
      cyc(0, 8'hFF, 1);
      cyc(0, 8'hFF, 0);
    end

    // Random persistent-request traffic
    rq = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) rq = rq ^ (8'd1 << $urandom_range(0, 7));
      cyc(($urandom_range(0, 149) == 0), rq, ($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
